// File: rtl/jogo_desafio_memoria_core.sv
// "Genius"-style memory game: control FSM, counters, timers, 16x4 RAM and debug outputs.
// Define DB_DISPLAYS_EN to drive the seven-segment db_* outputs; otherwise they are blanked.
module jogo_desafio_memoria_core #(
    parameter int T_ON      = 500,
    parameter int T_OFF     = 250,
    parameter int T_TIMEOUT = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [1:0] configuracao,
    input  logic [3:0] botoes,
    output logic [3:0] leds,
    output logic [2:0] leds_rgb,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic       pronto,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_limite_rodada,
    output logic [6:0] db_estado,
    output logic       db_igual,
    output logic       db_enderecoIgualLimite,
    output logic       db_timeout,
    output logic       db_escrita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_modo,
    output logic       db_configuracao
);

    localparam int T_SHOW_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW         = $clog2(T_SHOW_MAX + 1);
    localparam int TOW        = $clog2(T_TIMEOUT + 1);

    typedef enum logic [4:0] {
        INICIAL           = 5'b00000,
        PREPARACAO        = 5'b00001,
        INICIA_RODADA     = 5'b00010,
        MOSTRA_LED        = 5'b00011,
        ZERA_ENDERECO     = 5'b00100,
        MOSTRA_APAGADO    = 5'b00101,
        PROXIMO_LED       = 5'b00110,
        ESPERA            = 5'b00111,
        REGISTRA          = 5'b01000,
        COMPARA           = 5'b01001,
        PROXIMO_ENDERECO  = 5'b01010,
        INCREMENTA_LIMITE = 5'b01011,
        ADICIONA_JOGADA   = 5'b01101,
        REGISTRA_NOVA     = 5'b01110,
        ESCREVE           = 5'b01111,
        FIM_GANHOU        = 5'b10001,
        FIM_PERDEU        = 5'b10010,
        FIM_TIMEOUT       = 5'b10011
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     addr_q, addr_d;
    logic [3:0]     limite_q, limite_d;
    logic [3:0]     jogada_q, jogada_d;
    logic           modo_q, modo_d;
    logic           tmo_en_q, tmo_en_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [TOW-1:0] tmo_q, tmo_d;
    logic [3:0]     cap_q;
    logic           press_q, pulse_q;
    logic [3:0]     mem_q [16];
    logic           we;
    logic [3:0]     leds_d;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    logic waiting_q, waiting_d, end_eq, igual, tmo_term, tmo_fire, show_q;
    logic [3:0] final_lim;

    assign waiting_q = (state_q == ESPERA) || (state_q == ADICIONA_JOGADA);
    assign waiting_d = (state_d == ESPERA) || (state_d == ADICIONA_JOGADA);
    assign show_q    = (state_q == MOSTRA_LED) || (state_q == MOSTRA_APAGADO);
    assign end_eq    = (addr_q == limite_q);
    // Non-one-hot moves never match, even if such a value was written as a new step.
    assign igual     = is_onehot(jogada_q) && (jogada_q == mem_q[addr_q]);
    assign final_lim = modo_q ? 4'd3 : 4'd15;
    assign tmo_term  = (tmo_q == TOW'(T_TIMEOUT - 1));
    assign tmo_fire  = tmo_term && tmo_en_q;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        limite_d = limite_q;
        jogada_d = jogada_q;
        modo_d   = modo_q;
        tmo_en_d = tmo_en_q;
        we       = 1'b0;
        case (state_q)
            INICIAL:        if (jogar) state_d = PREPARACAO;
            PREPARACAO: begin
                addr_d   = 4'd0;
                limite_d = 4'd0;
                modo_d   = configuracao[0];
                tmo_en_d = configuracao[1];
                state_d  = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                addr_d  = 4'd0;
                state_d = MOSTRA_LED;
            end
            MOSTRA_LED:     if (tmr_q == TW'(T_ON - 1)) state_d = MOSTRA_APAGADO;
            MOSTRA_APAGADO: if (tmr_q == TW'(T_OFF - 1)) state_d = end_eq ? ZERA_ENDERECO : PROXIMO_LED;
            PROXIMO_LED: begin
                addr_d  = addr_q + 4'd1;
                state_d = MOSTRA_LED;
            end
            ZERA_ENDERECO: begin
                addr_d  = 4'd0;
                state_d = ESPERA;
            end
            ESPERA: begin
                if (pulse_q)       state_d = REGISTRA;
                else if (tmo_fire) state_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                jogada_d = cap_q;
                state_d  = COMPARA;
            end
            COMPARA: begin
                if (!igual)                      state_d = FIM_PERDEU;
                else if (!end_eq)                state_d = PROXIMO_ENDERECO;
                else if (limite_q == final_lim)  state_d = FIM_GANHOU;
                else                             state_d = INCREMENTA_LIMITE;
            end
            PROXIMO_ENDERECO: begin
                addr_d  = addr_q + 4'd1;
                state_d = ESPERA;
            end
            INCREMENTA_LIMITE: begin
                limite_d = limite_q + 4'd1;
                addr_d   = addr_q + 4'd1;
                state_d  = ADICIONA_JOGADA;
            end
            ADICIONA_JOGADA: begin
                if (pulse_q)       state_d = REGISTRA_NOVA;
                else if (tmo_fire) state_d = FIM_TIMEOUT;
            end
            REGISTRA_NOVA: begin
                jogada_d = cap_q;
                state_d  = ESCREVE;
            end
            ESCREVE: begin
                we      = 1'b1;
                state_d = INICIA_RODADA;
            end
            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (jogar) state_d = PREPARACAO;
            default:        state_d = INICIAL;
        endcase

        tmr_d = (show_q && (state_d == state_q)) ? tmr_q + 1'b1 : '0;
        // The idle counter saturates at its terminal value when timeouts are disabled.
        tmo_d = (waiting_q && (state_d == state_q) && !pulse_q)
              ? (tmo_term ? tmo_q : tmo_q + 1'b1) : '0;

        if (state_d == MOSTRA_LED) leds_d = mem_q[addr_d];
        else if (waiting_d)        leds_d = botoes;
        else                       leds_d = 4'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= INICIAL;
            addr_q   <= 4'd0;
            limite_q <= 4'd0;
            jogada_q <= 4'd0;
            modo_q   <= 1'b0;
            tmo_en_q <= 1'b0;
            tmr_q    <= '0;
            tmo_q    <= '0;
            cap_q    <= 4'd0;
            press_q  <= 1'b0;
            pulse_q  <= 1'b0;
            // NOTE: the RAM must reload its pattern on reset, so it is built from resettable flops.
            for (int i = 0; i < 16; i++) mem_q[i] <= 4'(1 << (i % 4));
            leds                   <= 4'd0;
            leds_rgb               <= 3'd0;
            ganhou                 <= 1'b0;
            perdeu                 <= 1'b0;
            timeout                <= 1'b0;
            pronto                 <= 1'b0;
            db_igual               <= 1'b0;
            db_enderecoIgualLimite <= 1'b0;
            db_timeout             <= 1'b0;
            db_escrita             <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q  <= state_d;
            addr_q   <= addr_d;
            limite_q <= limite_d;
            jogada_q <= jogada_d;
            modo_q   <= modo_d;
            tmo_en_q <= tmo_en_d;
            tmr_q    <= tmr_d;
            tmo_q    <= tmo_d;
            press_q  <= |botoes;
            pulse_q  <= (|botoes) && !press_q;
            if ((|botoes) && !press_q) cap_q <= botoes;
            if (we) mem_q[addr_q] <= jogada_q;
            leds     <= leds_d;
            leds_rgb <= {(state_d == FIM_PERDEU) || (state_d == FIM_TIMEOUT),
                         state_d == FIM_GANHOU, waiting_d};
            ganhou   <= (state_d == FIM_GANHOU);
            perdeu   <= (state_d == FIM_PERDEU);
            timeout  <= (state_d == FIM_TIMEOUT);
            pronto   <= (state_d == FIM_GANHOU) || (state_d == FIM_PERDEU) || (state_d == FIM_TIMEOUT);
            db_igual               <= is_onehot(jogada_d) && (jogada_d == mem_q[addr_d]);
            db_enderecoIgualLimite <= (addr_d == limite_d);
            db_timeout             <= (tmo_d == TOW'(T_TIMEOUT - 1));
            db_escrita             <= (state_d == ESCREVE);
        end
    end

    assign db_clock        = clock;
    assign db_iniciar      = jogar;
    assign db_modo         = modo_q;
    assign db_configuracao = tmo_en_q;

`ifdef DB_DISPLAYS_EN
    // Active-low segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
        return ~seg;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_contagem      <= 7'h40;
            db_memoria       <= 7'h40;
            db_jogadafeita   <= 7'h40;
            db_limite_rodada <= 7'h40;
            db_estado        <= 7'h40;
        end else begin
            db_contagem      <= hex7(addr_d);
            db_memoria       <= hex7(mem_q[addr_d]);
            db_jogadafeita   <= hex7(jogada_d);
            db_limite_rodada <= hex7(limite_d);
            db_estado        <= hex7(4'(state_d));
        end
    end
`else
    assign db_contagem      = 7'h7F;
    assign db_memoria       = 7'h7F;
    assign db_jogadafeita   = 7'h7F;
    assign db_limite_rodada = 7'h7F;
    assign db_estado        = 7'h7F;
`endif

endmodule

// File: tb/tb_jogo_desafio_memoria_core.sv
// Bench for jogo_desafio_memoria_core: plays randomized games against a sequence model.
module tb_jogo_desafio_memoria_core;
    localparam int T_ON = 4, T_OFF = 3, T_TO = 40;
`ifdef DB_DISPLAYS_EN
    localparam logic [6:0] SEG_RST = 7'h40;
`else
    localparam logic [6:0] SEG_RST = 7'h7F;
`endif

    logic       clock = 1'b0, reset = 1'b0, jogar = 1'b0;
    logic [1:0] configuracao = 2'b00;
    logic [3:0] botoes = 4'd0;
    logic [3:0] leds;
    logic [2:0] leds_rgb;
    logic       ganhou, perdeu, timeout, pronto;
    logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_limite_rodada, db_estado;
    logic       db_igual, db_enderecoIgualLimite, db_timeout, db_escrita;
    logic       db_clock, db_iniciar, db_modo, db_configuracao;

    jogo_desafio_memoria_core #(.T_ON(T_ON), .T_OFF(T_OFF), .T_TIMEOUT(T_TO)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao), .botoes(botoes),
        .leds(leds), .leds_rgb(leds_rgb), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .pronto(pronto), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_jogadafeita(db_jogadafeita), .db_limite_rodada(db_limite_rodada), .db_estado(db_estado),
        .db_igual(db_igual), .db_enderecoIgualLimite(db_enderecoIgualLimite),
        .db_timeout(db_timeout), .db_escrita(db_escrita), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_modo(db_modo), .db_configuracao(db_configuracao));

    always #5 clock = ~clock;

    int total = 0, bad = 0, writes = 0;
    logic [3:0] mdl [16];
    logic [3:0] runs [$];

    always @(negedge clock) if (db_escrita) writes <= writes + 1;

    task automatic init_model();
        for (int i = 0; i < 16; i++) mdl[i] = 4'(1 << (i % 4));
    endtask

    function automatic logic [3:0] rand_step();
        logic [3:0] v;
        v = 4'b0001 << $urandom_range(0, 3);
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        init_model();
    endtask

    task automatic start_game(input logic [1:0] cfg);
        configuracao = cfg;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    // Waits for a "waiting for a press" indication, recording each lit LED run on the way.
    task automatic wait_waiting(input int budget, output bit ok);
        logic [3:0] prev;
        prev = 4'd0;
        ok = 1'b0;
        runs.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (leds_rgb[0]) begin ok = 1'b1; break; end
            if (leds != 4'd0 && prev == 4'd0) runs.push_back(leds);
            prev = leds;
        end
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        botoes = v;
        repeat (hold) @(negedge clock);
        botoes = 4'd0;
        for (int i = 0; i < 8 && leds_rgb[0]; i++) @(negedge clock);
    endtask

    // One round: checks the replay, repeats it, then adds a step unless it is the last round.
    task automatic play_round(input int r, input bit last, input int hold, input logic [3:0] add);
        bit ok;
        wait_waiting(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL round%0d_wait: no press request", r); end
        total++;
        if (runs.size() != r + 1) begin
            bad++; $display("FAIL round%0d_replay_len: got %0d want %0d", r, runs.size(), r + 1);
        end else begin
            for (int i = 0; i <= r; i++) begin
                total++;
                if (runs[i] !== mdl[i]) begin
                    bad++; $display("FAIL round%0d_led%0d: got %b want %b", r, i, runs[i], mdl[i]);
                end
            end
        end
        for (int i = 0; i <= r; i++) begin
            if (i > 0) begin
                wait_waiting(50, ok);
                total++; if (!ok) begin bad++; $display("FAIL round%0d_step%0d_wait: not waiting", r, i); end
            end
            press(mdl[i], (hold == 0) ? int'($urandom_range(1, 6)) : hold);
            if (!(last && i == r)) begin
                total++;
                if ({ganhou, perdeu, timeout, pronto} !== 4'b0000) begin
                    bad++; $display("FAIL round%0d_step%0d_flags: got %b want 0000", r, i,
                                    {ganhou, perdeu, timeout, pronto});
                end
            end
        end
        if (!last) begin
            wait_waiting(50, ok);
            total++; if (!ok) begin bad++; $display("FAIL round%0d_add_wait: no add request", r); end
            press(add, (hold == 0) ? int'($urandom_range(1, 6)) : hold);
            mdl[r + 1] = add;
        end
    endtask

    task automatic wait_pronto();
        for (int i = 0; i < 8 && !pronto; i++) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        total++;
        if ({leds, leds_rgb, ganhou, perdeu, timeout, pronto, db_escrita, db_modo, db_configuracao} !== 14'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0",
                            {leds, leds_rgb, ganhou, perdeu, timeout, pronto, db_escrita, db_modo, db_configuracao});
        end
        total++;
        if (db_estado !== SEG_RST || db_contagem !== SEG_RST) begin
            bad++; $display("FAIL reset_seg: got %h/%h want %h", db_estado, db_contagem, SEG_RST);
        end
        do_reset();
        repeat (20) @(negedge clock);
        total++;
        if ({leds, leds_rgb, pronto} !== 8'd0) begin
            bad++; $display("FAIL idle_without_jogar: got %h want 0", {leds, leds_rgb, pronto});
        end
    endtask

    task automatic test_demo_win();
        int w0;
        logic [3:0] adds [3];
        adds[0] = 4'b0010; adds[1] = 4'b0100; adds[2] = 4'b1000;
        w0 = writes;
        start_game(2'b01);
        for (int r = 0; r < 4; r++) play_round(r, r == 3, 0, (r < 3) ? adds[r] : 4'd0);
        wait_pronto();
        total++;
        if ({ganhou, perdeu, timeout, pronto, leds_rgb} !== 7'b1001010) begin
            bad++; $display("FAIL demo_win_flags: got %b want 1001010", {ganhou, perdeu, timeout, pronto, leds_rgb});
        end
        total++; if (writes - w0 != 3) begin bad++; $display("FAIL demo_writes: got %0d want 3", writes - w0); end
        total++;
        if ({db_modo, db_configuracao} !== 2'b10) begin
            bad++; $display("FAIL demo_cfg: got %b want 10", {db_modo, db_configuracao});
        end
    endtask

    task automatic test_lose();
        bit ok;
        int k;
        start_game(2'b11);
        play_round(0, 1'b0, 0, 4'b0010);
        wait_waiting(400, ok);
        total++;
        if (!ok || runs.size() != 2 || runs[0] !== mdl[0] || runs[1] !== mdl[1]) begin
            bad++; $display("FAIL lose_replay: ok=%0d len=%0d want len 2", ok, runs.size());
        end
        botoes = 4'b1111;
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            k = i;
            if (perdeu) break;
        end
        botoes = 4'd0;
        total++; if (!perdeu || k > 4) begin bad++; $display("FAIL lose_latency: got %0d cycles want <=4", k); end
        total++;
        if ({ganhou, timeout, pronto, leds_rgb, db_configuracao} !== 7'b0011001) begin
            bad++; $display("FAIL lose_flags: got %b want 0011001", {ganhou, timeout, pronto, leds_rgb, db_configuracao});
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        start_game(2'b10);
        wait_waiting(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_wait: not waiting"); end
        n = 0;
        for (int i = 1; i <= T_TO + 10; i++) begin
            @(negedge clock);
            n = i;
            if (timeout) break;
        end
        total++; if (n != T_TO || !timeout) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, T_TO); end
        total++;
        if ({ganhou, perdeu, pronto, leds_rgb} !== 6'b001100) begin
            bad++; $display("FAIL timeout_flags: got %b want 001100", {ganhou, perdeu, pronto, leds_rgb});
        end
    endtask

    task automatic test_full_game();
        int w0;
        w0 = writes;
        start_game(2'b00);
        for (int r = 0; r < 16; r++) play_round(r, r == 15, 0, rand_step());
        wait_pronto();
        total++;
        if ({ganhou, perdeu, timeout, pronto, leds_rgb} !== 7'b1001010) begin
            bad++; $display("FAIL full_win_flags: got %b want 1001010", {ganhou, perdeu, timeout, pronto, leds_rgb});
        end
        total++; if (writes - w0 != 15) begin bad++; $display("FAIL full_writes: got %0d want 15", writes - w0); end
    endtask

    task automatic test_held_press();
        bit ok;
        start_game(2'b01);
        wait_waiting(400, ok);
        repeat (2 * T_TO) @(negedge clock);
        total++;
        if (!ok || {leds_rgb, timeout, pronto} !== 5'b00100) begin
            bad++; $display("FAIL idle_no_timeout: got %b want 00100", {leds_rgb, timeout, pronto});
        end
        press(4'b0001, 4);
        wait_waiting(50, ok);
        press(4'b0010, 4);
        mdl[1] = 4'b0010;
        wait_waiting(400, ok);
        total++;
        if (!ok || runs.size() != 2 || runs[1] !== 4'b0010) begin
            bad++; $display("FAIL held_replay: ok=%0d len=%0d want len 2", ok, runs.size());
        end
        press(4'b0001, 4);
        repeat (10) @(negedge clock);
        total++;
        if ({leds_rgb, perdeu, pronto} !== 5'b00100) begin
            bad++; $display("FAIL held_single_compare: got %b want 00100", {leds_rgb, perdeu, pronto});
        end
        press(4'b0010, 4);
        wait_waiting(50, ok);
        total++; if (!ok || perdeu) begin bad++; $display("FAIL held_second_step: ok=%0d perdeu=%0d", ok, perdeu); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        do_reset();
        start_game(2'b01);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            seen = (leds != 4'd0);
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_led_seen: no LED lit"); end
        reset = 1'b0;
        #1;
        total++;
        if ({leds, leds_rgb, ganhou, perdeu, timeout, pronto} !== 11'd0) begin
            bad++; $display("FAIL mid_reset_outputs: got %h want 0", {leds, leds_rgb, ganhou, perdeu, timeout, pronto});
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        init_model();
        repeat (20) @(negedge clock);
        total++; if ({leds, leds_rgb} !== 7'd0) begin bad++; $display("FAIL mid_idle: got %h want 0", {leds, leds_rgb}); end
        start_game(2'b01);
        play_round(0, 1'b0, 0, 4'b1000);
        wait_waiting(400, ok);
        total++;
        if (!ok || runs.size() != 2 || runs[0] !== 4'b0001 || runs[1] !== 4'b1000) begin
            bad++; $display("FAIL mid_restart_replay: ok=%0d len=%0d want len 2", ok, runs.size());
        end
    endtask

    initial begin
        init_model();
        test_reset();
        test_demo_win();
        test_lose();
        test_timeout();
        test_full_game();
        test_held_press();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
